fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, 32, address/PC width.
REQ-002 Parameter RESET_PC, XLEN'h0000_0000, PC loaded on reset.
REQ-003 Parameter DEPTH, 2, instruction buffer entries and maximum in-flight requests; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 redirect_valid  in  1  branch/jump redirect request.
REQ-007 redirect_pc  in  XLEN  redirect target.
REQ-008 imem_req_valid  out  1  fetch request valid.
REQ-009 imem_req_ready  in  1  memory accepts request.
REQ-010 imem_req_addr  out  XLEN  fetch address (equals fetch PC).
REQ-011 imem_resp_valid  in  1  in-order response, one per accepted request, earliest one cycle after acceptance.
REQ-012 imem_resp_data  in  32  instruction word.
REQ-013 out_valid  out  1  buffered instruction available to decode.
REQ-014 out_ready  in  1  decode accepts instruction.
REQ-015 out_pc  out  XLEN  PC of head instruction.
REQ-016 out_instr  out  32  head instruction word.

Function
REQ-017 Fetch PC register SHALL advance by 4 (modulo 2^XLEN, wrapping silently) on each imem_req_valid && imem_req_ready cycle; otherwise it holds.
REQ-018 imem_req_valid SHALL be high iff (in_flight + buffer_count) < DEPTH and redirect_valid is low.
REQ-019 On request acceptance the fetch PC SHALL be pushed into an in-order tag queue; the matching response pops it and writes {pc, instr} into the instruction buffer in the same edge.
REQ-020 The credit rule SHALL guarantee that the buffer never overflows; a response is never dropped for lack of space.
REQ-021 Handshakes: out_valid = buffer non-empty; an entry is popped on out_valid && out_ready; push and pop in the same cycle SHALL leave the count unchanged, including when the buffer is full or when the response fills an empty buffer (no bypass: out_valid rises one cycle after the response).
REQ-022 On redirect_valid: fetch PC <= {redirect_pc[XLEN-1:2], 2'b00}; buffer flushed; drop_cnt <= number of in-flight requests that remain unanswered after the current edge.
REQ-023 A response arriving in the redirect cycle SHALL be discarded and not counted in drop_cnt; responses arriving while drop_cnt > 0 SHALL be discarded and decrement drop_cnt.
REQ-024 In the redirect cycle, out_valid SHALL be forced low (no pop) and imem_req_valid SHALL be low; the first request to the new PC is issued no earlier than the next cycle.
REQ-025 Back-to-back redirects SHALL each take effect; the last one defines the fetch PC; drop_cnt always reflects all stale in-flight requests.
REQ-026 With continuous out_ready and single-cycle memory, throughput SHALL be one instruction per cycle once the pipeline is full.

Reset
REQ-027 During reset: fetch PC = RESET_PC, buffer and tag queue empty, in_flight = 0, drop_cnt = 0.
REQ-028 Outputs during reset and the cycle after: imem_req_valid = 0 while reset is high, out_valid = 0, out_pc = 0, out_instr = 0.
REQ-029 Reset mid-operation SHALL discard all buffered and in-flight state; responses to pre-reset requests are the memory's responsibility to squash.

Structure
REQ-030 Package fetch_pkg SHALL hold XLEN default, INSTR_W = 32, the PC increment constant 4, and typedef fetch_entry_t {pc, instr}.
REQ-031 One sub-module, fetch_fifo (parametrised WIDTH, DEPTH, synchronous flush input), SHALL be instantiated twice: tag queue and instruction buffer.
REQ-032 No latches; all sequential state is in clk-edge processes using synchronous reset.

Verification
REQ-033 Reset release, RESET_PC = 0x1000, memory always ready with 1-cycle latency, out_ready = 1 -> requests 0x1000, 0x1004, 0x1008...; out_pc follows the same sequence, one per cycle.
REQ-034 out_ready = 0 for 10 cycles, DEPTH = 2 -> exactly 2 requests are issued, then imem_req_valid stays low; release -> entries 0x1000, 0x1004 are delivered in order.
REQ-035 Redirect to 0x2003 with 2 requests in flight -> the next request address is 0x2000; both stale responses are discarded; first out_pc = 0x2000.
REQ-036 Redirect in the same cycle as a response and an out_valid/out_ready handshake -> the response is dropped, no pop occurs, and the buffer is empty the next cycle.
REQ-037 Fetch PC = 0xFFFF_FFFC accepted -> next request address is 0x0000_0000.
REQ-038 Reset asserted with a full buffer and one request in flight -> next cycle out_valid = 0 and the fetch PC is RESET_PC; once reset is released, the first request is to RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

  localparam int          XLEN_DEF = 32;
  localparam int          INSTR_W  = 32;
  localparam int unsigned PC_INC   = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used as the fetch tag queue and the instruction buffer.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != (PTR_W+1)'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited requests, in-order tag queue,
// instruction buffer and redirect handling with stale-response dropping.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = XLEN + INSTR_W;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  tag_pc;
  logic [CNT_W-1:0] tag_count;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] in_flight;
  logic [CNT_W:0]   credit_used;
  logic [ENT_W-1:0] head;
  logic             tag_empty;
  logic             buf_empty;
  logic             accept;
  logic             resp_fire;
  logic             resp_keep;
  logic             pop;
  logic             unused_pc_lsb;

  // Stale requests still occupy memory slots, so they count as in flight.
  assign in_flight = tag_count + drop_cnt;

  assign out_valid = !reset && !redirect_valid && !buf_empty;
  assign pop       = out_valid && out_ready;
  assign out_pc    = out_valid ? head[ENT_W-1:INSTR_W] : '0;
  assign out_instr = out_valid ? head[INSTR_W-1:0] : '0;

  // The entry leaving this cycle frees its slot at once, so a full pipeline
  // keeps one request per cycle with single-cycle memory.
  assign credit_used    = {1'b0, in_flight} + {1'b0, buf_count} - (CNT_W+1)'(pop);
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign resp_fire = imem_resp_valid && (in_flight != '0);
  assign resp_keep = resp_fire && !redirect_valid && (drop_cnt == '0) && !tag_empty;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt <= in_flight - CNT_W'(resp_fire);
    end else begin
      if (accept) fetch_pc <= fetch_pc + XLEN'(PC_INC);
      if (resp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (accept),
    .wdata (fetch_pc),
    .pop   (resp_keep),
    .rdata (tag_pc),
    .count (tag_count),
    .empty (tag_empty)
  );

  fetch_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (resp_keep),
    .wdata ({tag_pc, imem_resp_data}),
    .pop   (pop),
    .rdata (head),
    .count (buf_count),
    .empty (buf_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
  );

  typedef struct {
    logic [31:0] pc;
    logic        live;
  } pend_t;

  typedef struct {
    logic        rst;
    logic        ordy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_opc;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  logic prev_rst = 1'b1;

  // memory side
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  // reference model: fetch pc, requests the memory still owes, buffered entries
  logic [31:0] m_pc = RST_PC;
  pend_t       m_pend[$];
  logic [63:0] exp_q[$];

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic rst, input logic rd, input logic [31:0] rd_pc,
                       input logic ordy, input logic qrdy);
    logic         e_rv;
    logic         e_ov;
    logic         e_pop;
    logic         e_resp;
    int           used;
    fetch_entry_t ent;
    pend_t        p;
    @(negedge clk);
    reset          = rst;
    redirect_valid = rd;
    redirect_pc    = rd_pc;
    out_ready      = ordy;
    imem_req_ready = qrdy;
    e_resp = !rst && (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
    imem_resp_valid = e_resp;
    imem_resp_data  = e_resp ? instr_of(mem_addr_q[0]) : $urandom();
    #1;
    e_ov  = !rst && !rd && (exp_q.size() > 0);
    e_pop = e_ov && ordy;
    used  = m_pend.size() + exp_q.size() - (e_pop ? 1 : 0);
    e_rv  = !rst && !rd && (used < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    if (e_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    if (e_ov) begin
      ent = exp_q[0];
      chk("out_pc", out_pc, ent.pc);
      chk("out_instr", out_instr, ent.instr);
    end
    if (rst || prev_rst) begin
      chk("out_pc_reset", out_pc, 32'h0);
      chk("out_instr_reset", out_instr, 32'h0);
    end
    // memory: in-order responses, each at least one cycle after acceptance
    if (e_resp) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (imem_req_valid && qrdy) begin
      mem_addr_q.push_back(imem_req_addr);
      mem_due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    if (rst) begin
      mem_addr_q.delete();
      mem_due_q.delete();
    end
    // model state update at the edge
    if (rst) begin
      m_pc = RST_PC;
      m_pend.delete();
      exp_q.delete();
    end else if (rd) begin
      m_pc = {rd_pc[31:2], 2'b00};
      exp_q.delete();
      if (e_resp && (m_pend.size() > 0)) void'(m_pend.pop_front());
      foreach (m_pend[i]) m_pend[i].live = 1'b0;
    end else begin
      if (e_pop) void'(exp_q.pop_front());
      if (e_resp && (m_pend.size() > 0)) begin
        p = m_pend.pop_front();
        if (p.live) begin
          ent.pc    = p.pc;
          ent.instr = instr_of(p.pc);
          exp_q.push_back(ent);
        end
      end
      if (e_rv && qrdy) begin
        p.pc   = m_pc;
        p.live = 1'b1;
        m_pend.push_back(p);
        m_pc = m_pc + 32'd4;
      end
    end
    prev_rst = rst;
    cyc++;
  endtask

  task automatic run_until_req(input int max, output logic seen);
    seen = 1'b0;
    for (int n = 0; n < max && !seen; n++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      seen = imem_req_valid;
    end
  endtask

  task automatic run_until_out(input int max, output logic seen);
    seen = 1'b0;
    for (int n = 0; n < max && !seen; n++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      seen = out_valid;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt[22];
    logic        seen;
    logic        rd;
    logic [31:0] rpc;

    // reset, streaming at one per cycle, then decode stalled for 10 cycles
    vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h1004, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 32'h1008, 1'b1, 32'h1000};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 32'h100C, 1'b1, 32'h1004};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 32'h1010, 1'b1, 32'h1008};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 32'h1000, 1'b0, 32'h0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 32'h1004, 1'b0, 32'h0};
    for (int i = 11; i < 19; i++) vt[i] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1000};
    vt[19] = '{1'b0, 1'b1, 1'b1, 32'h1008, 1'b1, 32'h1000};
    vt[20] = '{1'b0, 1'b1, 1'b1, 32'h100C, 1'b1, 32'h1004};
    vt[21] = '{1'b0, 1'b1, 1'b1, 32'h1010, 1'b1, 32'h1008};

    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 22; i++) begin
      cycle(vt[i].rst, 1'b0, 32'h0, vt[i].ordy, 1'b1);
      chk("tv_req_valid", 32'(imem_req_valid), 32'(vt[i].e_rv));
      if (vt[i].e_rv) chk("tv_req_addr", imem_req_addr, vt[i].e_addr);
      chk("tv_out_valid", 32'(out_valid), 32'(vt[i].e_ov));
      if (vt[i].e_ov) chk("tv_out_pc", out_pc, vt[i].e_opc);
    end

    // redirect to an unaligned target with two requests outstanding
    lat_min = 3;
    lat_max = 3;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h2003, 1'b1, 1'b1);
    chk("s1_redirect_req_low", 32'(imem_req_valid), 32'h0);
    run_until_req(20, seen);
    chk("s1_req_seen", 32'(seen), 32'h1);
    chk("s1_req_addr", imem_req_addr, 32'h2000);
    run_until_out(20, seen);
    chk("s1_out_seen", 32'(seen), 32'h1);
    chk("s1_first_out_pc", out_pc, 32'h2000);

    // redirect colliding with a response and a decode handshake
    lat_min = 1;
    lat_max = 1;
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("s2_pre_out_valid", 32'(out_valid), 32'h1);
    chk("s2_pre_resp", 32'(imem_resp_valid), 32'h1);
    cycle(1'b0, 1'b1, 32'h3000, 1'b1, 1'b1);
    chk("s2_redir_out_valid", 32'(out_valid), 32'h0);
    chk("s2_redir_req_valid", 32'(imem_req_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("s2_after_out_valid", 32'(out_valid), 32'h0);
    chk("s2_after_req_addr", imem_req_addr, 32'h3000);
    run_until_out(20, seen);
    chk("s2_out_seen", 32'(seen), 32'h1);
    chk("s2_first_out_pc", out_pc, 32'h3000);

    // back-to-back redirects, the last one lands at the top of the address space
    lat_max = 2;
    cycle(1'b0, 1'b1, 32'h5000, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    run_until_req(20, seen);
    chk("s3_req_seen", 32'(seen), 32'h1);
    chk("s3_req_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    run_until_req(20, seen);
    chk("s3_req_seen_wrap", 32'(seen), 32'h1);
    chk("s3_req_addr_wrap", imem_req_addr, 32'h0);
    run_until_out(20, seen);
    chk("s3_out_top", out_pc, 32'hFFFF_FFFC);
    run_until_out(20, seen);
    chk("s3_out_wrap", out_pc, 32'h0);

    // reset with a buffered entry and a response in flight
    lat_min = 2;
    lat_max = 2;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("s4_reset_out_valid", 32'(out_valid), 32'h0);
    chk("s4_reset_req_valid", 32'(imem_req_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("s4_post_out_valid", 32'(out_valid), 32'h0);
    chk("s4_post_req_valid", 32'(imem_req_valid), 32'h1);
    chk("s4_post_req_addr", imem_req_addr, RST_PC);

    // randomized traffic against the model
    lat_min = 1;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 500) == 0) lat_max = int'($urandom_range(4, 1));
      rd  = ($urandom_range(29, 0) == 0);
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom();
      cycle(($urandom_range(199, 0) == 0), rd, rpc,
            ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
